// File: rtl/cond_exec_stage_pkg.sv
// Shared definitions for the execute-stage condition logic: condition codes,
// NZCV / FlagWrite bit indices and the registered D->E control word.
package cond_exec_stage_pkg;

    localparam int unsigned COND_W   = 4;
    localparam int unsigned FLAGS_W  = 4;
    localparam int unsigned ALUCTL_W = 4;
    localparam int unsigned FW_W     = 2;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

    typedef struct packed {
        logic [COND_W-1:0]   cond;
        logic                pc_src;
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_write;
        logic                branch;
        logic                alu_src;
        logic                no_write;
        logic [ALUCTL_W-1:0] alu_control;
        logic [FW_W-1:0]     flag_write;
    } ctrl_e_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether a 4-bit condition field
// passes against an NZCV flag set. Shared with the hazard unit.
module cond_check
    import cond_exec_stage_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Code 1111 falls into the default arm and is treated as always.
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage D->E control register, NZCV flag register and condition gating
// of write/branch/PC-source enables. CONDEX_STATS_EN adds a saturating squash counter.
module cond_exec_stage
    import cond_exec_stage_pkg::*;
#(
    parameter logic [FLAGS_W-1:0] FLAGS_RST = 4'b0000,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic [COND_W-1:0]   CondD,
    input  logic                PCSrcD,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                MemWriteD,
    input  logic                BranchD,
    input  logic                ALUSrcD,
    input  logic                NoWriteD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [FW_W-1:0]     FlagWriteD,
    input  logic [FLAGS_W-1:0]  ALUFlags,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic                ALUSrcE,
    output logic                MemtoRegE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic                PCSrcE,
    output logic                BranchTakenE,
    output logic                CondExE,
    output logic [FLAGS_W-1:0]  FlagsE,
    output logic [CNT_W-1:0]    SquashCnt
);

    ctrl_e_t              ctrl_d;
    ctrl_e_t              ctrl_q;
    logic [FLAGS_W-1:0]   flags_q;
    logic [FLAGS_W-1:0]   flags_next;
    logic                 cond_ex;
    logic                 flag_en;

    assign ctrl_d = '{
        cond:        CondD,
        pc_src:      PCSrcD,
        reg_write:   RegWriteD,
        mem_to_reg:  MemtoRegD,
        mem_write:   MemWriteD,
        branch:      BranchD,
        alu_src:     ALUSrcD,
        no_write:    NoWriteD,
        alu_control: ALUControlD,
        flag_write:  FlagWriteD
    };

    // Flush loads a bubble and overrides stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else if (FlushE) begin
            ctrl_q <= '0;
        end else if (!StallE) begin
            ctrl_q <= ctrl_d;
        end
    end

    cond_check u_cond_check (
        .cond    (ctrl_q.cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // The leaving instruction updates flags even when a flush arrives, unless stalled.
    assign flag_en = ~StallE & cond_ex;

    always_comb begin
        flags_next = flags_q;
        if (ctrl_q.flag_write[FW_NZ]) begin
            flags_next[FLAG_N] = ALUFlags[FLAG_N];
            flags_next[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (ctrl_q.flag_write[FW_CV]) begin
            flags_next[FLAG_C] = ALUFlags[FLAG_C];
            flags_next[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= FLAGS_RST;
        end else if (flag_en) begin
            flags_q <= flags_next;
        end
    end

`ifdef CONDEX_STATS_EN
    logic [CNT_W-1:0] squash_q;
    logic             squash_en;

    assign squash_en = ~StallE & ~cond_ex &
                       (ctrl_q.reg_write | ctrl_q.mem_write | ctrl_q.pc_src |
                        ctrl_q.branch | (|ctrl_q.flag_write));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_q <= '0;
        end else if (squash_en && (squash_q != {CNT_W{1'b1}})) begin
            squash_q <= squash_q + CNT_W'(1);
        end
    end

    assign SquashCnt = squash_q;
`else
    assign SquashCnt = '0;
`endif

    assign ALUControlE  = ctrl_q.alu_control;
    assign ALUSrcE      = ctrl_q.alu_src;
    assign MemtoRegE    = ctrl_q.mem_to_reg;
    assign RegWriteE    = ctrl_q.reg_write & cond_ex & ~ctrl_q.no_write;
    assign MemWriteE    = ctrl_q.mem_write & cond_ex;
    assign PCSrcE       = ctrl_q.pc_src & cond_ex;
    assign BranchTakenE = ctrl_q.branch & cond_ex;
    assign CondExE      = cond_ex;
    assign FlagsE       = flags_q;

endmodule
